// File: rtl/booth_ppgen.sv
// Radix-4 Booth partial-product generator feeding the booth_mul reduction tree.
// Recodes an 11-bit unsigned multiplier into six signed digits. Emits six
// unshifted 13-bit two's-complement rows (digit_i * a) through a two-stage,
// fully back-pressurable pipeline, and counts completed output handshakes.
module booth_ppgen #(
  parameter int unsigned CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [10:0]           a,
  input  logic [10:0]           b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [5:0][12:0]      ops,
  output logic [5:0][2:0]       digits,
  output logic [CNT_W-1:0]      txn_count
);

  // Stage 1: multiplicand plus recoded digits
  logic            s1_valid_q;
  logic [10:0]     s1_a_q;
  logic [5:0][2:0] s1_dig_q;

  // Stage 2: the registered outputs
  logic             s2_valid_q;
  logic [5:0][12:0] s2_ops_q;
  logic [5:0][2:0]  s2_dig_q;
  logic [CNT_W-1:0] cnt_q;

  logic             s2_free;
  logic             s1_adv;
  logic             in_fire;
  logic             out_fire;
  logic [12:0]      b_ext;
  logic [5:0][2:0]  rec_dig;
  logic [12:0]      a13;
  logic [5:0][12:0] rows;

  assign s2_free  = !s2_valid_q || out_ready;
  assign s1_adv   = s1_valid_q && s2_free;
  assign in_ready = !s1_valid_q || s2_free;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = s2_valid_q && out_ready;

  assign out_valid = s2_valid_q;
  assign ops       = s2_ops_q;
  assign digits    = s2_dig_q;
  assign txn_count = cnt_q;

  // Booth-recode the incoming multiplier; b_ext[0] is the implicit b[-1]
  always_comb begin
    b_ext   = {1'b0, b, 1'b0};
    rec_dig = '0;
    for (int i = 0; i < 6; i++) begin
      case (b_ext[2*i+2 -: 3])
        3'b001, 3'b010: rec_dig[i] = 3'b001;
        3'b011:         rec_dig[i] = 3'b010;
        3'b100:         rec_dig[i] = 3'b110;
        3'b101, 3'b110: rec_dig[i] = 3'b111;
        default:        rec_dig[i] = 3'b000;
      endcase
    end
  end

  // Select and negate the multiplicand per digit; |row| <= 4094 fits 13 bits
  always_comb begin
    a13  = {2'b00, s1_a_q};
    rows = '0;
    for (int i = 0; i < 6; i++) begin
      case (s1_dig_q[i])
        3'b001:  rows[i] = a13;
        3'b010:  rows[i] = a13 << 1;
        3'b110:  rows[i] = -(a13 << 1);
        3'b111:  rows[i] = -a13;
        default: rows[i] = '0;
      endcase
    end
  end

  // Stage 1: load on input transfer, otherwise drain into stage 2
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_dig_q   <= '0;
    end else if (in_fire) begin
      s1_valid_q <= 1'b1;
      s1_a_q     <= a;
      s1_dig_q   <= rec_dig;
    end else if (s1_adv) begin
      s1_valid_q <= 1'b0;
    end
  end

  // Stage 2: take stage 1 when free; holds unchanged while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      s2_ops_q   <= '0;
      s2_dig_q   <= '0;
    end else if (s1_adv) begin
      s2_valid_q <= 1'b1;
      s2_ops_q   <= rows;
      s2_dig_q   <= s1_dig_q;
    end else if (out_ready) begin
      s2_valid_q <= 1'b0;
    end
  end

  // Completed output handshakes, wrapping
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (out_fire) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule
